// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, single-word prefetch buffer and IR
// feeding the multicycle control FSM over a req/ack memory port.
module instr_fetch_unit #(
  parameter int ADDR_WIDTH  = 16,
  parameter int RESET_PC    = 0,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pcEn,
  input  logic                  pcIncOrSet,
  input  logic [ADDR_WIDTH-1:0] pcTarget,
  input  logic                  irEn,
  output logic                  memReq,
  output logic [ADDR_WIDTH-1:0] memAddr,
  input  logic                  memAck,
  input  logic [15:0]           memRdata,
  output logic [15:0]           instruction,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  fetchDone,
  output logic                  fetchErr
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FULL
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_RST = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);
  localparam logic [7:0]            TMO    = 8'(ACK_TIMEOUT);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           buf_q, buf_d;
  logic [15:0]           ir_q, ir_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    // IR takes the buffer before any same-cycle PC change drops it
    if (irEn && state_q == FULL) begin
      ir_d = buf_q;
    end

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        cnt_d   = '0;
      end
      REQ: begin
        if (memAck) begin
          buf_d   = memRdata;
          state_d = FULL;
        end else if (cnt_q + 8'd1 == TMO) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      FULL: begin
        state_d = FULL;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A PC change wins: any ack this cycle belongs to the old address
    if (pcEn) begin
      pc_d    = pcIncOrSet ? pcTarget : pc_q + PC_ONE;
      buf_d   = buf_q;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= PC_RST;
      buf_q   <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign memReq      = (state_q == REQ);
  assign fetchDone   = (state_q == FULL);
  assign memAddr     = pc_q;
  assign pc          = pc_q;
  assign instruction = ir_q;
  assign fetchErr    = err_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Program-counter and instruction-register stage directly upstream of the multicycle control FSM.
- Holds the PC and prefetches the 16-bit instruction word at the PC from instruction memory through a req/ack handshake.
- Presents the latched instruction word to the FSM and datapath.
- Consumes the FSM's pcEn, pcIncOrSet and irEn strobes.

Parameters:
- ADDR_WIDTH, 16, width of PC and instruction-memory word address
- RESET_PC, 0, PC value loaded on reset
- ACK_TIMEOUT, 15, max cycles memReq may wait for memAck before error and re-issue (1..255)

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- pcEn  input  1  PC update strobe from FSM (one cycle)
- pcIncOrSet  input  1  with pcEn: 0 = PC+1, 1 = load pcTarget
- pcTarget  input  ADDR_WIDTH  branch/jump target address
- irEn  input  1  latch prefetch buffer into instruction register
- memReq  output  1  instruction-memory read request, level
- memAddr  output  ADDR_WIDTH  read address, equals PC
- memAck  input  1  read data valid this cycle
- memRdata  input  16  read data
- instruction  output  16  instruction register
- pc  output  ADDR_WIDTH  current PC
- fetchDone  output  1  prefetch buffer holds the word for current PC
- fetchErr  output  1  sticky: an ack timeout occurred

Behaviour:
- Reset is asynchronous and active-low: while reset==0, all state is held at reset values, independent of clock.
  - pc = RESET_PC
  - instruction = 16'h0000
  - buffer invalid; fetchDone = 0; fetchErr = 0
  - memReq = 0; timeout counter = 0
  - state = IDLE
- Leaving reset mid-operation: any in-flight request is forgotten; an ack arriving afterwards while not in REQ is ignored.
- State machine has 3 states: IDLE, REQ, FULL.
- IDLE:
  - memReq = 0.
  - Always moves to REQ on the next cycle. IDLE is entered only from reset or after a PC change.
- REQ:
  - memReq = 1 and memAddr = pc, both stable until ack.
  - memAck=1 (and no pcEn this cycle): buffer <= memRdata; fetchDone=1 from the next cycle; go to FULL.
  - memAck=0: counter increments. When the counter reaches ACK_TIMEOUT:
    - fetchErr <= 1
    - counter <= 0
    - memReq drops for exactly one cycle (go IDLE), then re-issues
  - Counter clears on entry to REQ.
- FULL:
  - memReq = 0; fetchDone = 1; buffer held.
  - memAck in FULL or IDLE is ignored.
- pcEn=1, in any state, has priority over everything else in that cycle:
  - pc <= pcIncOrSet ? pcTarget : pc+1. Increment is modulo 2^ADDR_WIDTH, so all-ones wraps to 0.
  - buffer invalidated; fetchDone=0 next cycle; state <= IDLE.
  - A simultaneous memAck is discarded (stale address).
- irEn=1:
  - fetchDone=1: instruction <= buffer next edge. Buffer stays valid, so a repeat irEn reloads the same word.
  - fetchDone=0: instruction unchanged. No error is flagged; the FSM is responsible for the ordering.
- irEn and pcEn in the same cycle: irEn uses the old buffer if it is valid, then pcEn invalidates it.
- Latencies:
  - Reset release → memReq high after 1 cycle (IDLE→REQ).
  - Zero-wait memory (ack in first REQ cycle) → fetchDone high 2 cycles after a PC change.
- Outputs pc and instruction are registers, with no combinational path from inputs.
- memReq and fetchDone are decoded from state only.
- fetchErr clears only on reset.

Test Plan:
- Reset release, memory acks 1 cycle after memReq with 16'h5A13 at address 0 → memAddr=0; fetchDone=1; irEn then instruction=16'h5A13.
- pcEn=1, pcIncOrSet=0 at pc=16'hFFFF → pc=16'h0000, fetchDone=0, memReq re-asserted with memAddr=0 two cycles later.
- pcEn=1, pcIncOrSet=1, pcTarget=16'h0040 in the same cycle as memAck with 16'hBEEF → BEEF discarded, pc=16'h0040, new request issued, buffer gets the next ack data only.
- Hold memAck=0 with ACK_TIMEOUT=15 → after 15 REQ cycles fetchErr=1, memReq low for 1 cycle then high again; a later ack with 16'h1234 gives fetchDone=1 and fetchErr stays 1.
- irEn while fetchDone=0 (instruction=16'h5A13) → instruction stays 16'h5A13; irEn and pcEn together with buffer 16'h0F0F → instruction=16'h0F0F and fetchDone=0.
- Assert reset low mid-REQ, between clock edges → pc=RESET_PC, memReq=0 and instruction=0 immediately without a clock edge; an ack during reset is ignored.
